// File: rtl/systolic_pkg.sv
// Shared widths, array dimension and operand/accumulator types for the 3x3 systolic array.
// Latency: n/a (types only). Backpressure: none.
package systolic_pkg;
    localparam int DATA_W = 32;
    localparam int ACC_W  = 64;   // must be >= 2*DATA_W so the full product fits
    localparam int N      = 3;

    typedef logic [DATA_W-1:0] operand_t;
    typedef logic [ACC_W-1:0]  acc_t;
endpackage

// File: rtl/systolic_array_3x3_if.sv
// Operand edges (a1..a3 rows, b1..b3 columns) and the nine accumulator outputs c1..c9.
// Master drives operands, slave (the array) drives accumulators. No handshake: streams every cycle.
interface systolic_array_3x3_if;
    import systolic_pkg::*;

    operand_t a1, a2, a3;
    operand_t b1, b2, b3;
    acc_t     c1, c2, c3, c4, c5, c6, c7, c8, c9;

    modport master (output a1, a2, a3, b1, b2, b3,
                    input  c1, c2, c3, c4, c5, c6, c7, c8, c9);
    modport slave  (input  a1, a2, a3, b1, b2, b3,
                    output c1, c2, c3, c4, c5, c6, c7, c8, c9);
endinterface

// File: rtl/systolic_pe.sv
// Processing element: multiply-accumulate plus a/b pass-through registers.
// Latency: 1 edge input to acc/pass outputs. Backpressure: none, accumulates every cycle.
module systolic_pe
    import systolic_pkg::*;
(
    input  logic     clk,
    input  logic     rst,
    input  operand_t a_i,
    input  operand_t b_i,
    output operand_t a_o,
    output operand_t b_o,
    output acc_t     acc_o
);
    logic [2*DATA_W-1:0] prod;
    operand_t            a_q, b_q;
    acc_t                acc_q, acc_d;

    // Operands widened first so the multiply is full width and unsigned.
    assign prod  = {{DATA_W{1'b0}}, a_i} * {{DATA_W{1'b0}}, b_i};
    assign acc_d = acc_q + ACC_W'(prod);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_q   <= '0;
            b_q   <= '0;
            acc_q <= '0;
        end else begin
            a_q   <= a_i;
            b_q   <= b_i;
            acc_q <= acc_d;
        end
    end

    assign a_o   = a_q;
    assign b_o   = b_q;
    assign acc_o = acc_q;
endmodule

// File: rtl/systolic_array_3x3.sv
// 3x3 output-stationary systolic array, C = A x B; accumulators exposed as c1..c9 (row-major).
// Latency: 1 edge PE input to c. Backpressure: none. SYSTOLIC_INPUT_SKEW_EN adds internal input skew.
module systolic_array_3x3
    import systolic_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    systolic_array_3x3_if.slave  bus
);
    operand_t a_in   [N];
    operand_t b_in   [N];
    operand_t a_edge [N];
    operand_t b_edge [N];
    operand_t a_link [N][N];
    operand_t b_link [N][N];
    acc_t     c_w    [N][N];

    assign a_in[0] = bus.a1;
    assign a_in[1] = bus.a2;
    assign a_in[2] = bus.a3;
    assign b_in[0] = bus.b1;
    assign b_in[1] = bus.b2;
    assign b_in[2] = bus.b3;

    genvar i, j;
`ifdef SYSTOLIC_INPUT_SKEW_EN
    // Lane k is delayed by k cycles so the caller can drive unskewed rows/columns.
    for (i = 0; i < N; i++) begin : g_skew
        if (i == 0) begin : g_nodly
            assign a_edge[i] = a_in[i];
            assign b_edge[i] = b_in[i];
        end else begin : g_dly
            operand_t a_dly_q [i];
            operand_t b_dly_q [i];
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    for (int s = 0; s < i; s++) begin
                        a_dly_q[s] <= '0;
                        b_dly_q[s] <= '0;
                    end
                end else begin
                    a_dly_q[0] <= a_in[i];
                    b_dly_q[0] <= b_in[i];
                    for (int s = 1; s < i; s++) begin
                        a_dly_q[s] <= a_dly_q[s-1];
                        b_dly_q[s] <= b_dly_q[s-1];
                    end
                end
            end
            assign a_edge[i] = a_dly_q[i-1];
            assign b_edge[i] = b_dly_q[i-1];
        end
    end
`else
    for (i = 0; i < N; i++) begin : g_noskew
        assign a_edge[i] = a_in[i];
        assign b_edge[i] = b_in[i];
    end
`endif

    for (i = 0; i < N; i++) begin : g_row
        for (j = 0; j < N; j++) begin : g_col
            operand_t pe_a, pe_b;
            assign pe_a = (j == 0) ? a_edge[i] : a_link[i][(j == 0) ? 0 : j-1];
            assign pe_b = (i == 0) ? b_edge[j] : b_link[(i == 0) ? 0 : i-1][j];

            systolic_pe u_pe (
                .clk   (clk),
                .rst   (rst),
                .a_i   (pe_a),
                .b_i   (pe_b),
                .a_o   (a_link[i][j]),
                .b_o   (b_link[i][j]),
                .acc_o (c_w[i][j])
            );
        end
    end

    assign bus.c1 = c_w[0][0];
    assign bus.c2 = c_w[0][1];
    assign bus.c3 = c_w[0][2];
    assign bus.c4 = c_w[1][0];
    assign bus.c5 = c_w[1][1];
    assign bus.c6 = c_w[1][2];
    assign bus.c7 = c_w[2][0];
    assign bus.c8 = c_w[2][1];
    assign bus.c9 = c_w[2][2];
endmodule

// File: tb/tb_systolic_array_3x3.sv
// Directed bench for systolic_array_3x3: stimulus pushes hand-computed c1..c9 into a scoreboard,
// a monitor pops and compares after each edge (or right after an asynchronous reset assertion).
module tb_systolic_array_3x3;
    import systolic_pkg::*;

    typedef logic [8:0][ACC_W-1:0] cvec_t;
    typedef struct {
        cvec_t c;
        string name;
    } exp_t;

    logic clk;
    logic rst;
    systolic_array_3x3_if bus ();

    systolic_array_3x3 dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    exp_t  sb_q [$];
    event  chk_ev;
    int    vectors = 0;
    int    miscompares = 0;

    function automatic cvec_t mk(input acc_t v1, v2, v3, v4, v5, v6, v7, v8, v9);
        cvec_t r;
        r[0] = v1; r[1] = v2; r[2] = v3; r[3] = v4; r[4] = v5;
        r[5] = v6; r[6] = v7; r[7] = v8; r[8] = v9;
        return r;
    endfunction

    function automatic cvec_t actual();
        return mk(bus.c1, bus.c2, bus.c3, bus.c4, bus.c5, bus.c6, bus.c7, bus.c8, bus.c9);
    endfunction

    task automatic push(input cvec_t c, input string name);
        exp_t e;
        e.c = c;
        e.name = name;
        sb_q.push_back(e);
    endtask

    task automatic drive(input operand_t a1, a2, a3, b1, b2, b3);
        bus.a1 = a1; bus.a2 = a2; bus.a3 = a3;
        bus.b1 = b1; bus.b2 = b2; bus.b3 = b3;
    endtask

    // Drive inputs for the next edge; optionally queue what c1..c9 must read after it.
    task automatic step(input operand_t a1, a2, a3, b1, b2, b3,
                        input bit chk, input cvec_t c, input string name);
        @(negedge clk);
        drive(a1, a2, a3, b1, b2, b3);
        if (chk) push(c, name);
    endtask

    // Assert reset between edges and check the clear lands before the next rising edge.
    task automatic do_reset(input string name);
        @(negedge clk);
        #2;
        rst = 1'b0;
        drive('0, '0, '0, '0, '0, '0);
        push('0, name);
        -> chk_ev;
        @(negedge clk);
        rst = 1'b1;
    endtask

    // Monitor
    initial begin
        exp_t  e;
        cvec_t act;
        forever begin
            @(posedge clk or chk_ev);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                act = actual();
                vectors++;
                if (act !== e.c) begin
                    miscompares++;
                    for (int k = 0; k < 9; k++) begin
                        if (act[k] !== e.c[k]) begin
                            $display("FAIL %s: c%0d got %h want %h", e.name, k + 1, act[k], e.c[k]);
                            break;
                        end
                    end
                end
            end
        end
    end

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, %0d expectations pending", sb_q.size());
        miscompares++;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    logic [DATA_W-1:0] ma [3][3];
    logic [DATA_W-1:0] mb [3][3];
    operand_t          av [3];
    operand_t          bv [3];

    initial begin
        ma = '{'{1, 2, 3}, '{4, 5, 6}, '{7, 8, 9}};
        mb = '{'{9, 8, 7}, '{6, 5, 4}, '{3, 2, 1}};

        // Reset held with nonzero toggling inputs
        rst = 1'b0;
        drive(32'h11, 32'h22, 32'h33, 32'h44, 32'h55, 32'h66);
        #1;
        push('0, "rst_t0");
        -> chk_ev;
        for (int n = 0; n < 3; n++) begin
            step($urandom | 1, $urandom | 1, $urandom | 1, $urandom | 1, $urandom | 1,
                 $urandom | 1, 1'b1, '0, "rst_held");
        end
        @(negedge clk);
        rst = 1'b1;
        drive('0, '0, '0, '0, '0, '0);
        push('0, "post_rst_idle");

        // Single PE accumulate
        step(2, 0, 0, 3, 0, 0, 1'b1, mk(6, 0, 0, 0, 0, 0, 0, 0, 0), "pe_acc1");
        step(2, 0, 0, 3, 0, 0, 1'b1, mk(12, 0, 0, 0, 0, 0, 0, 0, 0), "pe_acc2");
        step(2, 0, 0, 3, 0, 0, 1'b1, mk(18, 0, 0, 0, 0, 0, 0, 0, 0), "pe_acc3");
        do_reset("rst_mid_stream");

        // Propagation: a1 pulse meets b2 one column over on the second edge
        step(5, 0, 0, 0, 7, 0, 1'b1, '0, "prop_e1");
        step(0, 0, 0, 0, 7, 0, 1'b1, mk(0, 35, 0, 0, 0, 0, 0, 0, 0), "prop_e2");
        step(0, 0, 0, 0, 7, 0, 1'b1, mk(0, 35, 0, 0, 0, 0, 0, 0, 0), "prop_e3");
        step(0, 0, 0, 0, 0, 0, 1'b1, mk(0, 35, 0, 0, 0, 0, 0, 0, 0), "prop_e4");
        do_reset("rst_after_prop");

        // Full 3x3 multiply over 7 edges, then one more to confirm stability
        for (int k = 0; k < 8; k++) begin
            for (int r = 0; r < 3; r++) begin
`ifdef SYSTOLIC_INPUT_SKEW_EN
                av[r] = (k < 3) ? ma[r][k] : '0;
                bv[r] = (k < 3) ? mb[k][r] : '0;
`else
                av[r] = (k - r >= 0 && k - r < 3) ? ma[r][k - r] : '0;
                bv[r] = (k - r >= 0 && k - r < 3) ? mb[k - r][r] : '0;
`endif
            end
            step(av[0], av[1], av[2], bv[0], bv[1], bv[2], (k >= 6),
                 mk(30, 24, 18, 84, 69, 54, 138, 114, 90), (k == 6) ? "matmul" : "matmul_hold");
        end
        do_reset("rst_after_matmul");

        // Accumulator wrap modulo 2^64
        step(32'hFFFF_FFFF, 0, 0, 32'hFFFF_FFFF, 0, 0, 1'b1,
             mk(64'hFFFF_FFFE_0000_0001, 0, 0, 0, 0, 0, 0, 0, 0), "wrap1");
        step(32'hFFFF_FFFF, 0, 0, 32'hFFFF_FFFF, 0, 0, 1'b1,
             mk(64'hFFFF_FFFC_0000_0002, 0, 0, 0, 0, 0, 0, 0, 0), "wrap2");
        step(0, 0, 0, 0, 0, 0, 1'b0, '0, "");
        do_reset("rst_after_wrap");

        for (int n = 0; n < 20 && sb_q.size() > 0; n++) @(posedge clk);
        #2;
        if (sb_q.size() > 0) begin
            $display("FAIL drain: %0d expectations never checked, want 0", sb_q.size());
            miscompares++;
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/systolic_array_3x3.md
Name:
systolic_array_3x3

Overview:
- 3x3 output-stationary systolic array for 3x3 matrix multiply, C = A x B.
- Operands stream in from the left edge (rows, a1..a3) and the top edge (columns, b1..b3).
- Each processing element (PE) accumulates the products it sees. The nine accumulators are exposed directly as c1..c9.
- Used as the compute core behind a matrix-operand sequencer that supplies skewed data.

Parameters:
- DATA_W, 32, operand width (unsigned).
- ACC_W, 64, accumulator/result width. Requirement: ACC_W >= 2*DATA_W.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset (asserted when 0).
- a1, a2, a3  input  DATA_W  left-edge operands for rows 1..3.
- b1, b2, b3  input  DATA_W  top-edge operands for columns 1..3.
- c1..c9  output  ACC_W  PE accumulators, row-major: c[(i-1)*3+j] = PE(i,j).

Behaviour:
- PE(i,j), i = row, j = column, holds three registers: a_reg, b_reg and acc.
- Each rising edge, PE(i,j) does:
  - acc <= acc + a_in*b_in
  - a_reg <= a_in
  - b_reg <= b_in
- PE input sources:
  - a_in = a_i when j=1, otherwise PE(i,j-1).a_reg.
  - b_in = b_j when i=1, otherwise PE(i-1,j).b_reg.
- Effective delays: a_i reaches column j after j-1 cycles; b_j reaches row i after i-1 cycles.
- Arithmetic: unsigned DATA_W x DATA_W full-width product, zero-extended to ACC_W. Accumulation wraps modulo 2^ACC_W; no saturation, no overflow flag.
- Outputs are the acc registers themselves: registered, no combinational path from inputs. Latency is 1 edge from PE input to c update.
- Reset (rst=0): all acc, a_reg and b_reg clear to 0 immediately, without waiting for clk. All c outputs read 0 while reset is held.
- First active edge after rst returns to 1 accumulates normally.
- Reset mid-stream discards all partial sums and pipeline contents.
- No clear or enable input: accumulation runs every cycle. Zero operands contribute nothing, so idle inputs must be driven to 0.
- Correct matrix product (base build) requires the caller to skew inputs:
  - at cycle k (k=0..4), a_i = A[i][k-(i-1)] and b_j = B[k-(j-1)][j]; 0 when the index is out of range.
  - Result is final after 7 edges (k=0..6) and stays stable while inputs remain 0.

Optional Feature:
- Macro: SYSTOLIC_INPUT_SKEW_EN.
- Defined: internal skew shift registers delay a_i by i-1 cycles and b_j by j-1 cycles (reset to 0 with rst).
  - Caller drives unskewed data: at cycle k (k=0..2), a_i = A[i][k] and b_j = B[k][j].
  - Product is final after 7 edges from k=0.
- Undefined: no skew logic; caller skews externally as in Behaviour.

Decomposition:
- Shared package systolic_pkg holds:
  - DATA_W and ACC_W defaults;
  - array dimension constant N=3;
  - the operand/accumulator typedefs.
- One sub-module: systolic_pe, holding the a/b pass-through registers, the multiplier and the accumulator.
- Top level instantiates a 3x3 generate grid of systolic_pe plus the optional skew registers.

Test Plan:
- Reset: drive rst=0 with nonzero inputs toggling -> c1..c9 = 0 throughout. Assert rst mid-stream -> all c return to 0 asynchronously, before the next clk edge.
- Single PE accumulate: a1=2, b1=3 held, others 0 -> c1 = 6, 12, 18 on successive edges. c2 stays 0 (b2=0) and c4 stays 0 (a2=0).
- Propagation delay: one-cycle pulse a1=5 with b2=7 held -> c2 becomes 35 exactly one edge after c1 would see a1 (i.e. the 2nd edge), and never changes again.
- Full 3x3 multiply, skewed inputs: A=[[1,2,3],[4,5,6],[7,8,9]], B=[[9,8,7],[6,5,4],[3,2,1]]. After 7 edges, c1..c9 = 30, 24, 18, 84, 69, 54, 138, 114, 90.
- Overflow wrap: a1=b1=0xFFFFFFFF for 2 cycles -> c1 = 0xFFFFFFFE00000001, then 0xFFFFFFFC00000002.
- With SYSTOLIC_INPUT_SKEW_EN: same A/B driven unskewed over k=0..2 -> after 7 edges c1..c9 = 30, 24, 18, 84, 69, 54, 138, 114, 90.
